// File: rtl/cb_exec_ctrl_if.sv
// Memory bus between the CB execution sequencer and the system bus.
// Carries a single outstanding read or write request with a shared ack.
interface cb_exec_ctrl_if;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/cb_exec_ctrl.sv
// Sequencer for CB-prefixed SM83 instructions: drives the shared ALU,
// writes back register/flags, and runs a bounded read-modify-write for (HL).
package cb_exec_ctrl_pkg;
    typedef logic [7:0] data_t;

    typedef struct packed {
        logic       z;
        logic       n;
        logic       h;
        logic       c;
        logic [3:0] rsvd;
    } flags_t;

    // Upper three bits select the operation class, lower three the bit index
    // or shift kind, so a CB opcode maps directly onto {class, opcode[5:3]}.
    typedef enum logic [5:0] {
        ALU_NOP   = 6'h00,
        ALU_RLC   = 6'h08, ALU_RRC   = 6'h09, ALU_RL    = 6'h0A, ALU_RR    = 6'h0B,
        ALU_SLA   = 6'h0C, ALU_SRA   = 6'h0D, ALU_SWAP  = 6'h0E, ALU_SRL   = 6'h0F,
        ALU_BIT_0 = 6'h10, ALU_BIT_1 = 6'h11, ALU_BIT_2 = 6'h12, ALU_BIT_3 = 6'h13,
        ALU_BIT_4 = 6'h14, ALU_BIT_5 = 6'h15, ALU_BIT_6 = 6'h16, ALU_BIT_7 = 6'h17,
        ALU_RES_0 = 6'h18, ALU_RES_1 = 6'h19, ALU_RES_2 = 6'h1A, ALU_RES_3 = 6'h1B,
        ALU_RES_4 = 6'h1C, ALU_RES_5 = 6'h1D, ALU_RES_6 = 6'h1E, ALU_RES_7 = 6'h1F,
        ALU_SET_0 = 6'h20, ALU_SET_1 = 6'h21, ALU_SET_2 = 6'h22, ALU_SET_3 = 6'h23,
        ALU_SET_4 = 6'h24, ALU_SET_5 = 6'h25, ALU_SET_6 = 6'h26, ALU_SET_7 = 6'h27
    } alu_op_t;

    localparam logic [2:0] ALU_GRP_SHIFT = 3'b001;
    localparam logic [2:0] ALU_GRP_BIT   = 3'b010;
    localparam logic [2:0] ALU_GRP_RES   = 3'b011;
    localparam logic [2:0] ALU_GRP_SET   = 3'b100;
endpackage

module cb_exec_ctrl
    import cb_exec_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [7:0]           opcode,
    input  flags_t               in_flags,
    input  logic [15:0]          hl,
    output logic [2:0]           rf_rd_sel,
    input  data_t                rf_rdata,
    output logic                 rf_we,
    output logic [2:0]           rf_wr_sel,
    output data_t                rf_wdata,
    output logic                 flags_we,
    output flags_t               flags_wdata,
    output alu_op_t              alu_op,
    output data_t                alu_op1,
    input  data_t                alu_result,
    input  flags_t               alu_flags,
    cb_exec_ctrl_if.master       mem,
    output logic                 done,
    output logic                 err
);

    localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MRD,
        S_MEXEC,
        S_MWR
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         opc_q, opc_d;
    alu_op_t            op_q, op_d;
    logic [15:0]        hl_q, hl_d;
    data_t              rdata_q, rdata_d;
    data_t              result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               is_shift, is_bit, is_swap, timeout_hit;
    logic [2:0]         reg_sel;
    flags_t             new_flags;

    logic               mem_rd_c, mem_wr_c;
    logic [15:0]        mem_addr_c;
    data_t              mem_wdata_c;

    logic               unused_flag_bits;

    function automatic alu_op_t decode_op(input logic [7:0] opc);
        logic [2:0] grp;
        unique case (opc[7:6])
            2'b00:   grp = ALU_GRP_SHIFT;
            2'b01:   grp = ALU_GRP_BIT;
            2'b10:   grp = ALU_GRP_RES;
            default: grp = ALU_GRP_SET;
        endcase
        return alu_op_t'({grp, opc[5:3]});
    endfunction

    assign is_shift    = (opc_q[7:6] == 2'b00);
    assign is_bit      = (opc_q[7:6] == 2'b01);
    assign is_swap     = (opc_q[7:3] == 5'b00110);
    assign reg_sel     = opc_q[2:0];
    assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == CNT_W'(ACK_TIMEOUT));

    // Only Z and C come from the ALU; N/H are fixed by the instruction class.
    always_comb begin
        new_flags = '0;
        if (is_shift) begin
            new_flags.z = alu_flags.z;
            new_flags.c = is_swap ? 1'b0 : alu_flags.c;
        end else if (is_bit) begin
            new_flags.z = alu_flags.z;
            new_flags.h = 1'b1;
            new_flags.c = in_flags.c;
        end
    end

    // NOTE: every output and next-state value gets a default before the case
    // so that no path leaves a signal unassigned and a latch is inferred.
    always_comb begin
        state_d     = state_q;
        opc_d       = opc_q;
        op_d        = op_q;
        hl_d        = hl_q;
        rdata_d     = rdata_q;
        result_d    = result_q;
        cnt_d       = cnt_q;

        op_ready    = 1'b0;
        rf_rd_sel   = 3'd0;
        rf_we       = 1'b0;
        rf_wr_sel   = 3'd0;
        rf_wdata    = '0;
        flags_we    = 1'b0;
        flags_wdata = '0;
        alu_op      = ALU_NOP;
        alu_op1     = '0;
        mem_rd_c    = 1'b0;
        mem_wr_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        done        = 1'b0;
        err         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    opc_d   = opcode;
                    op_d    = decode_op(opcode);
                    hl_d    = hl;
                    cnt_d   = '0;
                    state_d = (opcode[2:0] == 3'd6) ? S_MRD : S_EXEC;
                end
            end

            S_EXEC: begin
                rf_rd_sel = reg_sel;
                alu_op    = op_q;
                alu_op1   = rf_rdata;
                if (!is_bit) begin
                    rf_we     = 1'b1;
                    rf_wr_sel = reg_sel;
                    rf_wdata  = alu_result;
                end
                if (is_shift || is_bit) begin
                    flags_we    = 1'b1;
                    flags_wdata = new_flags;
                end
                done    = 1'b1;
                state_d = S_IDLE;
            end

            S_MRD: begin
                if (timeout_hit) begin
                    done    = 1'b1;
                    err     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    mem_rd_c   = 1'b1;
                    mem_addr_c = hl_q;
                    if (mem.mem_ack) begin
                        rdata_d = mem.mem_rdata;
                        state_d = S_MEXEC;
                    end else if (ACK_TIMEOUT != 0) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_MEXEC: begin
                alu_op   = op_q;
                alu_op1  = rdata_q;
                result_d = alu_result;
                if (is_shift || is_bit) begin
                    flags_we    = 1'b1;
                    flags_wdata = new_flags;
                end
                if (is_bit) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_MWR;
                end
            end

            S_MWR: begin
                if (timeout_hit) begin
                    done    = 1'b1;
                    err     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    mem_wr_c    = 1'b1;
                    mem_addr_c  = hl_q;
                    mem_wdata_c = result_q;
                    if (mem.mem_ack) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else if (ACK_TIMEOUT != 0) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its _d value from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opc_q    <= '0;
            op_q     <= ALU_NOP;
            hl_q     <= '0;
            rdata_q  <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            op_q     <= op_d;
            hl_q     <= hl_d;
            rdata_q  <= rdata_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mem.mem_rd    = mem_rd_c;
    assign mem.mem_wr    = mem_wr_c;
    assign mem.mem_addr  = mem_addr_c;
    assign mem.mem_wdata = mem_wdata_c;

    assign unused_flag_bits = ^{in_flags.z, in_flags.n, in_flags.h, in_flags.rsvd,
                                alu_flags.n, alu_flags.h, alu_flags.rsvd};

endmodule
